// File: rtl/vga_data_receiver_24bit.sv
// Receives a stream of 24-bit RGB pixels, tracks the raster position, accumulates a frame checksum
// and optionally checks the pixels against a vertical or horizontal colour-bar pattern.
module vga_data_receiver_24bit #(
  parameter int H_DISP      = 640,
  parameter int V_DISP      = 480,
  parameter int GAP_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] sys_data,
  input  logic        sys_we,
  input  logic [1:0]  chk_mode,
  output logic [10:0] rx_xpos,
  output logic [10:0] rx_ypos,
  output logic        frame_done,
  output logic        frame_err,
  output logic [31:0] frame_sum,
  output logic [19:0] pix_err_cnt,
  output logic [15:0] frame_cnt
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  // Bar sizes are clamped to 1 so tiny test rasters never divide by zero
  localparam int BAR_W = (H_DISP / 8 > 0) ? H_DISP / 8 : 1;
  localparam int BAR_H = (V_DISP / 8 > 0) ? V_DISP / 8 : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
  localparam logic [10:0] X_LAST = 11'(H_DISP - 1);
  localparam logic [10:0] Y_LAST = 11'(V_DISP - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q;
  logic [31:0]      sum_q, sum_next;
  logic [19:0]      err_q, err_next;
  logic [10:0]      bar_x, bar_y;
  logic [2:0]       bar_idx;
  logic [23:0]      exp_colour;
  logic             mismatch, last_pix, timeout;

  always_comb begin
    bar_x   = rx_xpos / 11'(BAR_W);
    bar_y   = rx_ypos / 11'(BAR_H);
    bar_idx = 3'd7;
    if (chk_mode == 2'd2) begin
      if (bar_y < 11'd7) bar_idx = bar_y[2:0];
    end else begin
      if (bar_x < 11'd7) bar_idx = bar_x[2:0];
    end
    case (bar_idx)
      3'd0:    exp_colour = 24'hFF0000;
      3'd1:    exp_colour = 24'h00FF00;
      3'd2:    exp_colour = 24'h0000FF;
      3'd3:    exp_colour = 24'hFFFFFF;
      3'd4:    exp_colour = 24'h000000;
      3'd5:    exp_colour = 24'hFFFF00;
      3'd6:    exp_colour = 24'hFF00FF;
      default: exp_colour = 24'h00FFFF;
    endcase
    mismatch = ((chk_mode == 2'd1) || (chk_mode == 2'd2)) && (sys_data != exp_colour);
    sum_next = sum_q + {8'd0, sys_data};
    err_next = (mismatch && (err_q != '1)) ? err_q + 20'd1 : err_q;
    last_pix = (rx_xpos == X_LAST) && (rx_ypos == Y_LAST);
    timeout  = (state_q == RECV) && !sys_we && (gap_q == GAP_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (sys_we && !last_pix) state_d = RECV;
      RECV: if ((sys_we && last_pix) || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: the final pixel of a frame is folded into the published results on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q       <= '0;
      sum_q       <= '0;
      err_q       <= '0;
      rx_xpos     <= '0;
      rx_ypos     <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_sum   <= '0;
      pix_err_cnt <= '0;
      frame_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (sys_we) begin
        gap_q <= '0;
        if (last_pix) begin
          frame_sum   <= sum_next;
          pix_err_cnt <= err_next;
          frame_cnt   <= frame_cnt + 16'd1;
          frame_done  <= 1'b1;
          frame_err   <= (err_next != '0);
          sum_q       <= '0;
          err_q       <= '0;
          rx_xpos     <= '0;
          rx_ypos     <= '0;
        end else begin
          sum_q <= sum_next;
          err_q <= err_next;
          if (rx_xpos == X_LAST) begin
            rx_xpos <= '0;
            rx_ypos <= rx_ypos + 11'd1;
          end else begin
            rx_xpos <= rx_xpos + 11'd1;
          end
        end
      end else if (timeout) begin
        frame_err <= 1'b1;
        gap_q     <= '0;
        sum_q     <= '0;
        err_q     <= '0;
        rx_xpos   <= '0;
        rx_ypos   <= '0;
      end else if (state_q == RECV) begin
        gap_q <= gap_q + 1'b1;
      end else begin
        gap_q <= '0;
      end
    end
  end

endmodule
